// File: rtl/trace_pkg.sv
// Shared types for the retire trace buffer: record kinds, trace record
// layout and capture FSM states.
package trace_pkg;

  localparam int TR_DATA_W = 16;

  typedef enum logic [2:0] {
    NOP   = 3'd0,
    REG   = 3'd1,
    LOAD  = 3'd2,
    STORE = 3'd3,
    HALT  = 3'd4
  } trace_kind_e;

  // f2 carries the load address alongside the pc
  typedef struct packed {
    trace_kind_e          kind;
    logic [31:0]          inum;
    logic [TR_DATA_W-1:0] pc;
    logic [TR_DATA_W-1:0] f0;
    logic [TR_DATA_W-1:0] f1;
    logic [TR_DATA_W-1:0] f2;
  } trace_entry_t;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RUN     = 3'd1,
    S_DRAIN   = 3'd2,
    S_DONE    = 3'd3,
    S_TIMEOUT = 3'd4
  } trace_state_e;

endpackage

// File: rtl/trace_fifo.sv
// First-word-fall-through FIFO of trace records; the extra pointer
// bit tells full from empty.
module trace_fifo #(
  parameter type T     = logic [7:0],
  parameter int  DEPTH = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  T     din,
  input  logic pop,
  output logic full,
  output logic empty,
  output T     head
);

  localparam int AW = $clog2(DEPTH);

  T             mem [DEPTH];
  logic [AW:0]  wptr_q, wptr_d;
  logic [AW:0]  rptr_q, rptr_d;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) &&
                 (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign head  = mem[rptr_q[AW-1:0]];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push) wptr_d = wptr_q + 1'b1;
    if (pop)  rptr_d = rptr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/retire_trace_buffer.sv
// Retire trace capture: kind decode, counters and capture FSM over a FIFO.
// Optional watchdog enabled by defining TRACE_WDOG_EN.
module retire_trace_buffer
  import trace_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int REG_W      = 4,
  parameter int DEPTH      = 16,
  parameter int WDOG_LIMIT = 100000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cap_en,
  input  logic              ret_valid,
  input  logic [DATA_W-1:0] ret_pc,
  input  logic [DATA_W-1:0] ret_wdata,
  input  logic [DATA_W-1:0] ret_maddr,
  input  logic [DATA_W-1:0] ret_mdata,
  input  logic [REG_W-1:0]  ret_wreg,
  input  logic              ret_regwrite,
  input  logic              ret_memread,
  input  logic              ret_memwrite,
  input  logic              ret_halt,
  output logic              rd_valid,
  input  logic              rd_ready,
  output trace_entry_t      rd_entry,
  output logic [31:0]       inst_cnt,
  output logic [31:0]       cycle_cnt,
  output logic [15:0]       drop_cnt,
  output logic              overflow,
  output logic              halted,
  output logic              done,
  output logic              timeout
);

  trace_state_e state_q, state_d;
  logic [31:0]  inst_cnt_q, cycle_cnt_q;
  logic [15:0]  drop_cnt_q;
  logic         overflow_q, halted_q;

  trace_entry_t rec, head;
  logic         fifo_full, fifo_empty;
  logic         take, push, pop, drop;

  assign take = (state_q == S_RUN) && ret_valid;
  assign pop  = rd_valid && rd_ready;
  assign push = take && (!fifo_full || pop);
  assign drop = take && fifo_full && !pop;

  always_comb begin
    rec      = '0;
    rec.inum = inst_cnt_q;
    rec.pc   = TR_DATA_W'(ret_pc);
    if (ret_regwrite && ret_memread) begin
      rec.kind = LOAD;
      rec.f0   = TR_DATA_W'(ret_wreg);
      rec.f1   = TR_DATA_W'(ret_wdata);
      rec.f2   = TR_DATA_W'(ret_maddr);
    end else if (ret_regwrite) begin
      rec.kind = REG;
      rec.f0   = TR_DATA_W'(ret_wreg);
      rec.f1   = TR_DATA_W'(ret_wdata);
    end else if (ret_halt) begin
      rec.kind = HALT;
    end else if (ret_memwrite) begin
      rec.kind = STORE;
      rec.f0   = TR_DATA_W'(ret_maddr);
      rec.f1   = TR_DATA_W'(ret_mdata);
    end else begin
      rec.kind = NOP;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (cap_en) state_d = S_RUN;
      S_RUN: begin
        if (take && ret_halt) state_d = S_DRAIN;
        else if (!cap_en)     state_d = S_IDLE;
      end
      S_DRAIN: if (fifo_empty) state_d = S_DONE;
      default: state_d = state_q;
    endcase
`ifdef TRACE_WDOG_EN
    if ((state_q == S_RUN || state_q == S_DRAIN) &&
        cycle_cnt_q >= 32'(WDOG_LIMIT))
      state_d = S_TIMEOUT;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      inst_cnt_q  <= '0;
      cycle_cnt_q <= '0;
      drop_cnt_q  <= '0;
      overflow_q  <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (take) inst_cnt_q <= inst_cnt_q + 32'd1;
      if (state_q == S_RUN && cycle_cnt_q != '1)
        cycle_cnt_q <= cycle_cnt_q + 32'd1;
      if (drop) begin
        overflow_q <= 1'b1;
        if (drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + 16'd1;
      end
      if (take && ret_halt) halted_q <= 1'b1;
    end
  end

  trace_fifo #(
    .T     (trace_entry_t),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (rec),
    .pop   (pop),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (head)
  );

  // Status is forced quiet while reset is held, not just after the edge
  assign rd_valid  = rst_n && !fifo_empty;
  assign rd_entry  = rd_valid ? head : '0;
  assign inst_cnt  = inst_cnt_q;
  assign cycle_cnt = cycle_cnt_q;
  assign drop_cnt  = drop_cnt_q;
  assign overflow  = rst_n && overflow_q;
  assign halted    = rst_n && halted_q;
  assign done      = rst_n && (state_q == S_DONE);
`ifdef TRACE_WDOG_EN
  assign timeout   = rst_n && (state_q == S_TIMEOUT);
`else
  assign timeout   = 1'b0;
`endif

endmodule
